shift_sequencer: RTL

//  Multi-cycle variable-shift unit for the MiniRISC ALU (SLL/SRL/SRA by 0..31).

---
 rtl/shift_sequencer_pkg.sv | 17 +
 rtl/shift_sequencer_step.sv | 58 +++++
 rtl/shift_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types for the MiniRISC multi-cycle shifter: shift op codes and sequencer state codes.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_NOP = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_sequencer_step.sv
// Single combinational shift step: moves din by BIG_STEP bits or by 1 bit, according to op.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BIG_STEP = 4
) (
    input  logic [DATA_W-1:0] din,
    input  shift_op_e         op,
    input  logic              big,
    output logic [DATA_W-1:0] dout
);

    logic              fill;
    logic [DATA_W-1:0] left_big;
    logic [DATA_W-1:0] left_one;
    logic [DATA_W-1:0] right_big;
    logic [DATA_W-1:0] right_one;

    // SRA replicates the current MSB on every step, so the sign survives repeated steps
    assign fill = (op == SH_SRA) ? din[DATA_W-1] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            if (gi >= BIG_STEP) begin : g_lb
                assign left_big[gi] = din[gi-BIG_STEP];
            end else begin : g_lb0
                assign left_big[gi] = 1'b0;
            end
            if (gi >= 1) begin : g_l1
                assign left_one[gi] = din[gi-1];
            end else begin : g_l10
                assign left_one[gi] = 1'b0;
            end
            if (gi + BIG_STEP < DATA_W) begin : g_rb
                assign right_big[gi] = din[gi+BIG_STEP];
            end else begin : g_rbf
                assign right_big[gi] = fill;
            end
            if (gi + 1 < DATA_W) begin : g_r1
                assign right_one[gi] = din[gi+1];
            end else begin : g_r1f
                assign right_one[gi] = fill;
            end
        end
    endgenerate

    always_comb begin
        dout = din;
        case (op)
            SH_SLL:          dout = big ? left_big : left_one;
            SH_SRL, SH_SRA:  dout = big ? right_big : right_one;
            default:         dout = din;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: iterates shift_step with coarse steps first, then 1-bit steps.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SHAMT_W  = 5,
    parameter int BIG_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [DATA_W-1:0]  operand_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [DATA_W-1:0]  result_o
);

    localparam logic [SHAMT_W-1:0] BIG_CNT = SHAMT_W'(BIG_STEP);

    state_e             state_reg, state_next;
    shift_op_e          op_reg;
    logic [DATA_W-1:0]  acc_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [SHAMT_W-1:0] cnt_step;
    logic [DATA_W-1:0]  acc_step;
    logic               big_step;
    logic               accept;

    assign accept   = start_i & (state_reg == S_IDLE) & ~flush_i;
    assign big_step = (cnt_reg >= BIG_CNT);
    assign cnt_step = big_step ? (cnt_reg - BIG_CNT) : (cnt_reg - SHAMT_W'(1));

    shift_step #(
        .DATA_W   (DATA_W),
        .BIG_STEP (BIG_STEP)
    ) u_step (
        .din  (acc_reg),
        .op   (op_reg),
        .big  (big_step),
        .dout (acc_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_next = ((shamt_i == '0) || (shift_op_e'(op_i) == SH_NOP))
                                     ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: if (cnt_step == '0) state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o  = (state_reg == S_IDLE);
        busy_o   = (state_reg == S_SHIFT) || (state_reg == S_DONE);
        done_o   = (state_reg == S_DONE);
        result_o = acc_reg;
    end

    // A flush freezes acc and cnt where they are; only the state returns to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            op_reg  <= SH_NOP;
        end else if (accept) begin
            acc_reg <= operand_i;
            cnt_reg <= shamt_i;
            op_reg  <= shift_op_e'(op_i);
        end else if ((state_reg == S_SHIFT) && !flush_i) begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_step;
        end
    end

endmodule
